// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave = the unit itself; master = the requester plus the data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_address, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer: byte-addressed requests to word-addressed memory,
// big-endian lanes, sign/zero-extended loads, read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int ADDR_WORD_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                size_q;
  logic                      unsigned_q;
  logic [ADDR_WORD_BITS+1:0] addr_q;
  logic [31:0]               wdata_q;
  logic [31:0]               merge_q;
  logic [31:0]               rdata_q;
  logic                      resp_valid_q;
  logic [1:0]                resp_err_q;

  logic                      accept;
  logic [1:0]                req_err;
  logic [7:0]                rd_lane [4];
  logic [3:0]                lane_hit;
  logic [31:0]               merged_word;
  logic [7:0]                load_byte;
  logic [15:0]               load_half;
  logic [31:0]               load_ext;

  assign accept = (state_q == IDLE) && bus.req_valid;

  // Misalignment outranks the range check.
  always_comb begin
    req_err = 2'b00;
    if (bus.req_size == 2'b11 ||
        (bus.req_size == 2'b01 && bus.req_addr[0]) ||
        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
      req_err = 2'b01;
    else if (bus.req_addr[31:ADDR_WORD_BITS+2] != '0)
      req_err = 2'b10;
  end

  // Byte k of a word sits at [31-8k -: 8]; merge replaces the addressed lanes with store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi]  = bus.mem_read_data[31-8*gi -: 8];
      assign lane_hit[gi] = (size_q == 2'b00) ? (addr_q[1:0] == 2'(gi)) : (addr_q[1] == 1'(gi / 2));
      assign merged_word[31-8*gi -: 8] = !lane_hit[gi] ? merge_q[31-8*gi -: 8] :
                                         ((size_q == 2'b01 && (gi % 2) == 0) ? wdata_q[15:8]
                                                                             : wdata_q[7:0]);
    end
  endgenerate

  always_comb begin
    load_byte = rd_lane[addr_q[1:0]];
    load_half = addr_q[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];
    case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{16{~unsigned_q & load_half[15]}}, load_half};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && req_err == 2'b00) begin
          if (!bus.req_store)             state_d = LOAD;
          else if (bus.req_size == 2'b10) state_d = STORE;
          else                            state_d = RMW_RD;
        end
      end
      RMW_RD:  state_d = RMW_WR;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes come only from registered state, never from req_*.
  always_comb begin
    bus.req_ready      = (state_q == IDLE);
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_write_data = 32'h0;
    case (state_q)
      LOAD, RMW_RD: bus.mem_read = 1'b1;
      STORE: begin
        bus.mem_write      = 1'b1;
        bus.mem_write_data = wdata_q;
      end
      RMW_WR: begin
        bus.mem_write      = 1'b1;
        bus.mem_write_data = merged_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      rdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 2'b00;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept) begin
        size_q     <= bus.req_size;
        unsigned_q <= bus.req_unsigned;
        addr_q     <= bus.req_addr[ADDR_WORD_BITS+1:0];
        wdata_q    <= bus.req_wdata;
        if (req_err != 2'b00) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= req_err;
        end
      end
      case (state_q)
        LOAD: begin
          rdata_q      <= load_ext;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 2'b00;
        end
        STORE, RMW_WR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 2'b00;
        end
        RMW_RD: merge_q <= bus.mem_read_data;
        default: ;
      endcase
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.mem_address = {{(32-ADDR_WORD_BITS){1'b0}}, addr_q[ADDR_WORD_BITS+1:2]};

endmodule
